// File: rtl/decode_stage_pipe.sv
// Instruction decode stage: register file, immediate extension, load-use interlock, ID/EX register.
// Optional macro ID_WB_BYPASS_EN makes register reads see a same-cycle write-back (write-through).
module decode_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_instruction,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic              i_wb_en,
    input  logic [4:0]        i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_dest_sel,
    input  logic [1:0]        i_ext_mode,
    input  logic              i_ex_mem_read,
    input  logic [4:0]        i_ex_rt,
    output logic              o_ready,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_src1,
    output logic [DATA_W-1:0] o_src2,
    output logic [DATA_W-1:0] o_imm,
    output logic [4:0]        o_RS,
    output logic [4:0]        o_RT,
    output logic [4:0]        o_RD,
    output logic [4:0]        o_dest_addr,
    output logic [5:0]        o_opcode,
    output logic [5:0]        o_funct
);

    localparam int         AW      = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam logic [5:0] DEPTH_L = 6'(RF_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        dest;
        logic [5:0]        opcode;
        logic [5:0]        funct;
    } idex_t;

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rf_q [RF_DEPTH];
    logic [DATA_W-1:0] src1Rd;
    logic [DATA_W-1:0] src2Rd;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] immExt;
    logic              hazard;
    idex_t             idex_d;
    idex_t             idex_q;

    assign opcode = i_instruction[31:26];
    assign rs     = i_instruction[25:21];
    assign rt     = i_instruction[20:16];
    assign rd     = i_instruction[15:11];
    assign funct  = i_instruction[5:0];
    assign imm    = i_instruction[15:0];

    // Index 0 and indices beyond the implemented depth are hardwired to zero.
    function automatic logic legalIdx(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < DEPTH_L);
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else if (i_wb_en && legalIdx(i_wb_addr)) begin
            rf_q[i_wb_addr[AW-1:0]] <= i_wb_data;
        end
    end

    always_comb begin
        src1Rd = '0;
        src2Rd = '0;
        if (legalIdx(rs)) src1Rd = rf_q[rs[AW-1:0]];
        if (legalIdx(rt)) src2Rd = rf_q[rt[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
        if (i_wb_en && legalIdx(i_wb_addr) && (i_wb_addr == rs)) src1Rd = i_wb_data;
        if (i_wb_en && legalIdx(i_wb_addr) && (i_wb_addr == rt)) src2Rd = i_wb_data;
`endif
    end

    assign sext = {{(DATA_W-16){imm[15]}}, imm};

    always_comb begin
        immExt = sext;
        case (i_ext_mode)
            2'b00: immExt = sext;
            2'b01: immExt = {{(DATA_W-16){1'b0}}, imm};
            2'b10: immExt = sext << 16;
            2'b11: immExt = sext << 2;
            default: immExt = sext;
        endcase
    end

    // The interlock has no state: it drops as soon as EX moves the load along.
    assign hazard  = i_valid && i_ex_mem_read && (i_ex_rt != 5'd0) &&
                     ((i_ex_rt == rs) || (i_ex_rt == rt));
    assign o_stall = hazard && !i_flush;
    assign o_ready = !o_stall;

    always_comb begin
        idex_d = '0;
        if (i_valid && !i_flush && !o_stall) begin
            idex_d.valid  = 1'b1;
            idex_d.src1   = src1Rd;
            idex_d.src2   = src2Rd;
            idex_d.imm    = immExt;
            idex_d.rs     = rs;
            idex_d.rt     = rt;
            idex_d.rd     = rd;
            idex_d.dest   = i_dest_sel ? rd : rt;
            idex_d.opcode = opcode;
            idex_d.funct  = funct;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) idex_q <= '0;
        else          idex_q <= idex_d;
    end

    assign o_valid     = idex_q.valid;
    assign o_src1      = idex_q.src1;
    assign o_src2      = idex_q.src2;
    assign o_imm       = idex_q.imm;
    assign o_RS        = idex_q.rs;
    assign o_RT        = idex_q.rt;
    assign o_RD        = idex_q.rd;
    assign o_dest_addr = idex_q.dest;
    assign o_opcode    = idex_q.opcode;
    assign o_funct     = idex_q.funct;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: a register-file model predicts each ID/EX load.
module tb_decode_stage_pipe;

    localparam int DATA_W   = 32;
    localparam int RF_DEPTH = 32;
    localparam logic [63:0] DMASK = (DATA_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

    logic              i_clk;
    logic              i_reset;
    logic [31:0]       i_instruction;
    logic              i_valid;
    logic              i_flush;
    logic              i_wb_en;
    logic [4:0]        i_wb_addr;
    logic [DATA_W-1:0] i_wb_data;
    logic              i_dest_sel;
    logic [1:0]        i_ext_mode;
    logic              i_ex_mem_read;
    logic [4:0]        i_ex_rt;
    logic              o_ready;
    logic              o_stall;
    logic              o_valid;
    logic [DATA_W-1:0] o_src1;
    logic [DATA_W-1:0] o_src2;
    logic [DATA_W-1:0] o_imm;
    logic [4:0]        o_RS;
    logic [4:0]        o_RT;
    logic [4:0]        o_RD;
    logic [4:0]        o_dest_addr;
    logic [5:0]        o_opcode;
    logic [5:0]        o_funct;

    typedef struct {
        logic        valid;
        logic [63:0] src1;
        logic [63:0] src2;
        logic [63:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  dest;
        logic [5:0]  opcode;
        logic [5:0]  funct;
    } exp_t;

    exp_t        scoreboard[$];
    logic [63:0] modelRf [32];
    int          checkCount = 0;
    int          passCount  = 0;

    decode_stage_pipe #(.DATA_W(DATA_W), .RF_DEPTH(RF_DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instruction(i_instruction), .i_valid(i_valid),
        .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_dest_sel(i_dest_sel), .i_ext_mode(i_ext_mode), .i_ex_mem_read(i_ex_mem_read),
        .i_ex_rt(i_ex_rt), .o_ready(o_ready), .o_stall(o_stall), .o_valid(o_valid),
        .o_src1(o_src1), .o_src2(o_src2), .o_imm(o_imm), .o_RS(o_RS), .o_RT(o_RT), .o_RD(o_RD),
        .o_dest_addr(o_dest_addr), .o_opcode(o_opcode), .o_funct(o_funct)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] modelRead(input logic [4:0] idx, input logic wbEn,
                                              input logic [4:0] wbAddr, input logic [63:0] wbData);
        if (idx == 5'd0 || int'(idx) >= RF_DEPTH) return 64'd0;
`ifdef ID_WB_BYPASS_EN
        if (wbEn && wbAddr == idx) return wbData & DMASK;
`endif
        return modelRf[idx];
    endfunction

    function automatic logic [63:0] modelExt(input logic [15:0] imm, input logic [1:0] mode);
        logic [63:0] s64;
        s64 = {{48{imm[15]}}, imm};
        case (mode)
            2'b00:   return s64 & DMASK;
            2'b01:   return {48'd0, imm};
            2'b10:   return (s64 << 16) & DMASK;
            default: return (s64 << 2) & DMASK;
        endcase
    endfunction

    // Drives one cycle of inputs, checks the interlock, predicts the ID/EX load and compares after the edge.
    task automatic applyStimulus(input logic rstN, input logic [31:0] instr, input logic valid,
                                 input logic flush, input logic wbEn, input logic [4:0] wbAddr,
                                 input logic [63:0] wbData, input logic destSel, input logic [1:0] extMode,
                                 input logic exMemRead, input logic [4:0] exRt);
        exp_t e;
        exp_t got;
        logic hazard;
        logic stallExp;
        i_reset = rstN; i_instruction = instr; i_valid = valid; i_flush = flush;
        i_wb_en = wbEn; i_wb_addr = wbAddr; i_wb_data = wbData[DATA_W-1:0];
        i_dest_sel = destSel; i_ext_mode = extMode; i_ex_mem_read = exMemRead; i_ex_rt = exRt;
        #1;
        hazard   = valid && exMemRead && (exRt != 0) && ((exRt == instr[25:21]) || (exRt == instr[20:16]));
        stallExp = hazard && !flush;
        checkOutput("stall", 64'(o_stall), 64'(stallExp));
        checkOutput("ready", 64'(o_ready), 64'(!stallExp));

        e = '{valid: 1'b0, src1: 64'd0, src2: 64'd0, imm: 64'd0, rs: 5'd0, rt: 5'd0,
              rd: 5'd0, dest: 5'd0, opcode: 6'd0, funct: 6'd0};
        if (rstN && !flush && !stallExp && valid) begin
            e.valid  = 1'b1;
            e.src1   = modelRead(instr[25:21], wbEn, wbAddr, wbData);
            e.src2   = modelRead(instr[20:16], wbEn, wbAddr, wbData);
            e.imm    = modelExt(instr[15:0], extMode);
            e.rs     = instr[25:21];
            e.rt     = instr[20:16];
            e.rd     = instr[15:11];
            e.dest   = destSel ? instr[15:11] : instr[20:16];
            e.opcode = instr[31:26];
            e.funct  = instr[5:0];
        end
        scoreboard.push_back(e);

        @(posedge i_clk);
        #1;
        if (!rstN) begin
            for (int i = 0; i < 32; i++) modelRf[i] = 64'd0;
        end else if (wbEn && wbAddr != 0 && int'(wbAddr) < RF_DEPTH) begin
            modelRf[wbAddr] = wbData & DMASK;
        end

        if (scoreboard.size() == 0) begin
            checkOutput("sb_empty", 64'd1, 64'd0);
        end else begin
            got = scoreboard.pop_front();
            checkOutput("valid",  64'(o_valid),     64'(got.valid));
            checkOutput("src1",   64'(o_src1),      got.src1);
            checkOutput("src2",   64'(o_src2),      got.src2);
            checkOutput("imm",    64'(o_imm),       got.imm);
            checkOutput("rs",     64'(o_RS),        64'(got.rs));
            checkOutput("rt",     64'(o_RT),        64'(got.rt));
            checkOutput("rd",     64'(o_RD),        64'(got.rd));
            checkOutput("dest",   64'(o_dest_addr), 64'(got.dest));
            checkOutput("opcode", 64'(o_opcode),    64'(got.opcode));
            checkOutput("funct",  64'(o_funct),     64'(got.funct));
        end
    endtask

    initial begin
        logic [31:0] instr;
        for (int i = 0; i < 32; i++) modelRf[i] = 64'd0;
        i_reset = 1'b0; i_instruction = '0; i_valid = 1'b0; i_flush = 1'b0; i_wb_en = 1'b0;
        i_wb_addr = '0; i_wb_data = '0; i_dest_sel = 1'b0; i_ext_mode = 2'b00;
        i_ex_mem_read = 1'b0; i_ex_rt = '0;
        @(posedge i_clk);
        #1;

        // Reset for two cycles with a valid rs=5 decode offered, then decode it for real.
        applyStimulus(0, 32'h00A0_0000, 1, 0, 0, 5'd0, 64'd0, 0, 2'b00, 0, 5'd0);
        applyStimulus(0, 32'h00A0_0000, 1, 0, 0, 5'd0, 64'd0, 0, 2'b00, 0, 5'd0);
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        applyStimulus(1, 32'h00A0_0000, 1, 0, 0, 5'd0, 64'd0, 0, 2'b00, 0, 5'd0);
        checkOutput("rst_src1", 64'(o_src1), 64'd0);

        // Write x3, then decode add-style instruction reading it.
        applyStimulus(1, 32'h0, 0, 0, 1, 5'd3, 64'h1234_5678, 0, 2'b00, 0, 5'd0);
        applyStimulus(1, 32'h0062_2020, 1, 0, 0, 5'd0, 64'd0, 1, 2'b00, 0, 5'd0);
        checkOutput("wr_src1_lit", 64'(o_src1), 64'h1234_5678);
        checkOutput("wr_dest_lit", 64'(o_dest_addr), 64'd4);

        // Same-cycle write and read of x3.
        applyStimulus(1, 32'h0062_2020, 1, 0, 1, 5'd3, 64'hDEAD_BEEF, 1, 2'b00, 0, 5'd0);
`ifdef ID_WB_BYPASS_EN
        checkOutput("byp_src1_lit", 64'(o_src1), 64'hDEAD_BEEF);
`else
        checkOutput("nobyp_src1_lit", 64'(o_src1), 64'h1234_5678);
`endif
        applyStimulus(1, 32'h0062_2020, 1, 0, 0, 5'd0, 64'd0, 1, 2'b00, 0, 5'd0);
        checkOutput("after_wr_lit", 64'(o_src1), 64'hDEAD_BEEF);

        // Load-use interlock held two cycles, then EX advances and the instruction issues.
        applyStimulus(1, 32'h0062_2020, 1, 0, 0, 5'd0, 64'd0, 1, 2'b00, 1, 5'd3);
        checkOutput("lu_valid_lit", 64'(o_valid), 64'd0);
        applyStimulus(1, 32'h0062_2020, 1, 0, 0, 5'd0, 64'd0, 1, 2'b00, 1, 5'd3);
        applyStimulus(1, 32'h0062_2020, 1, 0, 0, 5'd0, 64'd0, 1, 2'b00, 0, 5'd3);
        checkOutput("lu_issue_lit", 64'(o_valid), 64'd1);

        // Flush wins over a simultaneous hazard; x0 write is ignored.
        applyStimulus(1, 32'h0062_2020, 1, 1, 1, 5'd0, 64'hFFFF_FFFF, 1, 2'b00, 1, 5'd3);
        checkOutput("fl_valid_lit", 64'(o_valid), 64'd0);
        applyStimulus(1, 32'h0000_0000, 1, 0, 0, 5'd0, 64'd0, 0, 2'b00, 0, 5'd0);
        checkOutput("x0_lit", 64'(o_src1), 64'd0);

        // Immediate extension modes with imm=0x8004.
        applyStimulus(1, 32'h2000_8004, 1, 0, 0, 5'd0, 64'd0, 0, 2'b00, 0, 5'd0);
        checkOutput("ext00_lit", 64'(o_imm), 64'hFFFF_8004 | (DMASK & ~64'hFFFF_FFFF));
        applyStimulus(1, 32'h2000_8004, 1, 0, 0, 5'd0, 64'd0, 0, 2'b01, 0, 5'd0);
        checkOutput("ext01_lit", 64'(o_imm), 64'h0000_8004);
        applyStimulus(1, 32'h2000_8004, 1, 0, 0, 5'd0, 64'd0, 0, 2'b10, 0, 5'd0);
        checkOutput("ext10_lit", 64'(o_imm), 64'h8004_0000 | (DMASK & ~64'hFFFF_FFFF));
        applyStimulus(1, 32'h2000_8004, 1, 0, 0, 5'd0, 64'd0, 0, 2'b11, 0, 5'd0);
        checkOutput("ext11_lit", 64'(o_imm), 64'hFFFE_0010 | (DMASK & ~64'hFFFF_FFFF));

        // Randomised traffic with small register indices to provoke hazards.
        for (int n = 0; n < 60; n++) begin
            instr = $urandom;
            instr[25:21] = 5'($urandom_range(0, 7));
            instr[20:16] = 5'($urandom_range(0, 7));
            applyStimulus(1, instr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          {$urandom, $urandom}, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
        end

        // Reset during a stall: interlock stays combinational, state and register file clear.
        applyStimulus(1, 32'h0000_0000, 0, 0, 1, 5'd3, 64'h5555_AAAA, 0, 2'b00, 0, 5'd0);
        applyStimulus(0, 32'h0062_2020, 1, 0, 1, 5'd4, 64'h7777_7777, 1, 2'b00, 1, 5'd3);
        applyStimulus(1, 32'h0064_2020, 1, 0, 0, 5'd0, 64'd0, 1, 2'b00, 0, 5'd0);
        checkOutput("rst_rf_lit", 64'(o_src1), 64'd0);
        checkOutput("rst_rf4_lit", 64'(o_src2), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
